// File: rtl/game_control_if.sv
// game_control_if: the signals exchanged between the game sequencing FSM and the datapath.
// master = sequencer (drives the phase strobes), slave = datapath (drives enable and the done levels).
interface game_control_if #(
    parameter int FRAME_W = 16
);
    logic               enable;
    logic               idle_done;
    logic               gen_move_done;
    logic               check_collide_done;
    logic               draw_map_done;
    logic               draw_link_done;
    logic               draw_enemies_done;

    logic               init;
    logic               idle;
    logic               gen_move;
    logic               check_collide;
    logic               apply_act_link;
    logic               move_enemies;
    logic               draw_map;
    logic               draw_link;
    logic               draw_enemies;
    logic [FRAME_W-1:0] frame_count;
    logic               timeout_err;
    logic [3:0]         state_dbg;

    modport master (
        input  enable, idle_done, gen_move_done, check_collide_done,
               draw_map_done, draw_link_done, draw_enemies_done,
        output init, idle, gen_move, check_collide, apply_act_link, move_enemies,
               draw_map, draw_link, draw_enemies, frame_count, timeout_err, state_dbg
    );

    modport slave (
        output enable, idle_done, gen_move_done, check_collide_done,
               draw_map_done, draw_link_done, draw_enemies_done,
        input  init, idle, gen_move, check_collide, apply_act_link, move_enemies,
               draw_map, draw_link, draw_enemies, frame_count, timeout_err, state_dbg
    );
endinterface

// File: rtl/game_control.sv
// game_control: per-frame phase sequencer for the game datapath.
// Optional watchdog: define GAME_CTRL_WATCHDOG_EN to enable the wait-phase timeout
// (forced advance plus sticky timeout_err); undefined, wait phases block until done.
//
// state          | meaning
// INIT (0)       | parked; waits for enable, frame counter held at 0
// IDLE (1)       | waits for the frame tick (idle_done); exits to INIT if enable is low
// GEN_MOVE (2)   | waits for gen_move_done
// CHECK_COLL (3) | waits for check_collide_done
// APPLY_LINK (4) | single cycle
// MOVE_ENEM (5)  | single cycle
// DRAW_MAP (6)   | waits for draw_map_done
// DRAW_LINK (7)  | waits for draw_link_done
// DRAW_ENEM (8)  | waits for draw_enemies_done; exit to IDLE completes a frame
module game_control #(
    parameter logic [20:0] TIMEOUT_CYCLES = 21'd1500000,
    parameter int          FRAME_W        = 16
) (
    input  logic           clock,
    input  logic           reset,
    game_control_if.master bus
);

    typedef enum logic [3:0] {
        S_INIT          = 4'd0,
        S_IDLE          = 4'd1,
        S_GEN_MOVE      = 4'd2,
        S_CHECK_COLLIDE = 4'd3,
        S_APPLY_LINK    = 4'd4,
        S_MOVE_ENEMIES  = 4'd5,
        S_DRAW_MAP      = 4'd6,
        S_DRAW_LINK     = 4'd7,
        S_DRAW_ENEMIES  = 4'd8
    } state_t;

    state_t             r_state;
    state_t             w_next;
    state_t             w_succ;
    logic               r_first;
    logic [8:0]         r_strobe;
    logic [8:0]         w_strobe_next;
    logic [FRAME_W-1:0] r_frame;
    logic               w_wait;
    logic               w_done;
    logic               w_accept;
    logic               w_timeout;

    // Per-state decode: is this a wait phase, which done level it watches, and where it goes next.
    always_comb begin
        w_wait = 1'b0;
        w_done = 1'b0;
        w_succ = S_INIT;
        case (r_state)
            S_INIT:          w_succ = S_IDLE;
            S_IDLE:          begin w_wait = 1'b1; w_done = bus.idle_done;          w_succ = S_GEN_MOVE;      end
            S_GEN_MOVE:      begin w_wait = 1'b1; w_done = bus.gen_move_done;      w_succ = S_CHECK_COLLIDE; end
            S_CHECK_COLLIDE: begin w_wait = 1'b1; w_done = bus.check_collide_done; w_succ = S_APPLY_LINK;    end
            S_APPLY_LINK:    w_succ = S_MOVE_ENEMIES;
            S_MOVE_ENEMIES:  w_succ = S_DRAW_MAP;
            S_DRAW_MAP:      begin w_wait = 1'b1; w_done = bus.draw_map_done;      w_succ = S_DRAW_LINK;     end
            S_DRAW_LINK:     begin w_wait = 1'b1; w_done = bus.draw_link_done;     w_succ = S_DRAW_ENEMIES;  end
            S_DRAW_ENEMIES:  begin w_wait = 1'b1; w_done = bus.draw_enemies_done;  w_succ = S_IDLE;          end
            default:         w_succ = S_INIT;
        endcase
    end

`ifdef GAME_CTRL_WATCHDOG_EN
    logic [20:0] r_wd;
    logic        r_timeout_err;

    assign w_timeout = w_wait && (r_wd == (TIMEOUT_CYCLES - 21'd1));

    // Watchdog: restarts on every state entry, counts cycles spent in a wait phase.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                r_wd <= 21'd0;
        else if (w_next != r_state) r_wd <= 21'd0;
        else if (w_wait)           r_wd <= r_wd + 21'd1;
        else                       r_wd <= 21'd0;
    end

    // Sticky error: only a forced advance sets it; a done in the same cycle wins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                     r_timeout_err <= 1'b0;
        else if (w_next == S_INIT)      r_timeout_err <= 1'b0;
        else if (w_timeout && !w_accept) r_timeout_err <= 1'b1;
    end

    assign bus.timeout_err = r_timeout_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
    assign bus.timeout_err  = 1'b0;
`endif

    // Next state and next strobe vector; a wait phase ignores its done in its first cycle.
    always_comb begin
        w_next   = r_state;
        w_accept = w_wait && !r_first && w_done;
        case (r_state)
            S_INIT:         if (bus.enable) w_next = S_IDLE;
            S_APPLY_LINK,
            S_MOVE_ENEMIES: w_next = w_succ;
            S_IDLE: begin
                if (!bus.enable)                w_next = S_INIT;
                else if (w_accept || w_timeout) w_next = w_succ;
            end
            S_GEN_MOVE, S_CHECK_COLLIDE, S_DRAW_MAP, S_DRAW_LINK, S_DRAW_ENEMIES:
                if (w_accept || w_timeout) w_next = w_succ;
            default:        w_next = S_INIT;
        endcase
        w_strobe_next = 9'd1 << w_next;
    end

    // State register plus first-cycle marker for the stale-done guard.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_INIT;
            r_first <= 1'b1;
        end else begin
            r_state <= w_next;
            r_first <= (w_next != r_state);
        end
    end

    // Registered one-hot strobes, aligned with the state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_strobe <= 9'd1;
        else        r_strobe <= w_strobe_next;
    end

    // Completed-frame counter: bumps on DRAW_ENEMIES -> IDLE, held at zero while parked.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_frame <= '0;
        else if (w_next == S_INIT)
            r_frame <= '0;
        else if (r_state == S_DRAW_ENEMIES && w_next == S_IDLE)
            r_frame <= r_frame + {{(FRAME_W-1){1'b0}}, 1'b1};
    end

    assign bus.init           = r_strobe[0];
    assign bus.idle           = r_strobe[1];
    assign bus.gen_move       = r_strobe[2];
    assign bus.check_collide  = r_strobe[3];
    assign bus.apply_act_link = r_strobe[4];
    assign bus.move_enemies   = r_strobe[5];
    assign bus.draw_map       = r_strobe[6];
    assign bus.draw_link      = r_strobe[7];
    assign bus.draw_enemies   = r_strobe[8];
    assign bus.frame_count    = r_frame;
    assign bus.state_dbg      = r_state;

endmodule
